uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding several byte requesters into one UART transmitter.
// Optional packet lock: define UART_ARB_PKTLOCK_EN.
module uart_tx_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ack,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DRAIN
  } state_e;

  state_e           state_q;
  logic [IW-1:0]    last_q;
  logic [IW-1:0]    win_q;
  logic             started_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic [N_REQ-1:0] req_ack_q;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] idle_grant;
  logic             pick_ok;
  logic [IW-1:0]    pick_idx;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

`ifdef UART_ARB_PKTLOCK_EN
  logic          lock_q;
  logic [IW-1:0] lock_id_q;
  logic          pend_last_q;

  assign elig       = lock_q ? (req_valid & onehot(lock_id_q)) : req_valid;
  assign idle_grant = lock_q ? onehot(lock_id_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      pend_last_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && started_q && tx_ready && pick_ok)
        pend_last_q <= req_last[pick_idx];
      if (state_q == S_SEND && tx_ready) begin
        lock_q    <= !pend_last_q;
        lock_id_q <= win_q;
      end
    end
  end
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign elig        = req_valid;
  assign idle_grant  = '0;
`endif

  // Search starts one past the last accepted requester; lowest offset wins.
  always_comb begin
    int          t;
    logic [IW-1:0] cand;
    pick_ok  = 1'b0;
    pick_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      t = int'(last_q) + k;
      if (t >= N_REQ) t = t - N_REQ;
      cand = IW'(t);
      if (elig[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= IW'(N_REQ - 1);
      win_q      <= '0;
      started_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      req_ack_q  <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      started_q <= 1'b1;
      req_ack_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (started_q && tx_ready && pick_ok) begin
            tx_data_q  <= req_data[{pick_idx, 3'b000} +: 8];
            tx_valid_q <= 1'b1;
            grant_q    <= onehot(pick_idx);
            win_q      <= pick_idx;
            busy_q     <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_valid_q && tx_ready) begin
            tx_valid_q <= 1'b0;
            req_ack_q  <= onehot(win_q);
            last_q     <= win_q;
            state_q    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The transmitter drops ready once it starts shifting the byte.
          if (!tx_ready) begin
            grant_q <= idle_grant;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant    = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, round-robin,
// backpressure, packet lock and reset mid-transfer.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  grant;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] seq_b [3][8];
  logic       seq_l [3][8];
  int         seq_n [3];
  int         ptr   [3];
  int         ack_cnt [3];
  logic [7:0] acc [$];

  uart_tx_arbiter #(.N_REQ(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ack  (req_ack),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '1;
    tx_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_req(input int i);
    if (ptr[i] < seq_n[i]) begin
      req_valid[i]       = 1'b1;
      req_data[8*i +: 8] = seq_b[i][ptr[i]];
      req_last[i]        = seq_l[i][ptr[i]];
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic set_seq(input int i, input int n, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2,
                         input logic [2:0] lst);
    seq_n[i]    = n;
    seq_b[i][0] = b0;
    seq_b[i][1] = b1;
    seq_b[i][2] = b2;
    seq_l[i][0] = lst[0];
    seq_l[i][1] = lst[1];
    seq_l[i][2] = lst[2];
  endtask

  task automatic wait_valid(input string tag);
    int c = 0;
    while (!tx_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!tx_valid) check(tag, 32'(tx_valid), 32'd1);
  endtask

  // Transmitter model: accepts, then drops ready for two cycles.
  task automatic run_traffic(input int nbytes);
    int got  = 0;
    int cyc  = 0;
    int hold = 0;
    bit drop = 0;
    acc.delete();
    for (int i = 0; i < 3; i++) begin
      ptr[i]     = 0;
      ack_cnt[i] = 0;
      load_req(i);
    end
    tx_ready = 1'b1;
    while ((got < nbytes || hold > 0 || drop) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (req_ack[i]) begin
          ack_cnt[i]++;
          ptr[i]++;
          load_req(i);
        end
      end
      if (hold > 0) begin
        hold--;
        if (hold == 0) tx_ready = 1'b1;
      end else if (drop) begin
        drop     = 0;
        tx_ready = 1'b0;
        hold     = 2;
      end else if (tx_valid && tx_ready) begin
        acc.push_back(tx_data);
        got++;
        drop = 1;
      end
    end
    req_valid = '0;
    if (cyc >= 400) check("traffic_timeout", got, nbytes);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit stable;
    logic [7:0] exp31 [4];

    // Single byte and post-reset latency
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '1;
    tx_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(req_ack), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    req_valid = 3'b001;
    req_data  = 24'h00004F;
    tx_ready  = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    check("first_edge_no_grant", 32'(tx_valid), 0);
    @(negedge clk);
    check("single_tx_valid", 32'(tx_valid), 1);
    check("single_tx_data", 32'(tx_data), 32'h4F);
    check("single_grant", 32'(grant), 32'b001);
    check("single_busy", 32'(busy), 1);
    @(negedge clk);
    check("single_ack", 32'(req_ack), 32'b001);
    check("single_tx_valid_low", 32'(tx_valid), 0);
    req_valid = '0;
    tx_ready  = 1'b0;
    @(negedge clk);
    check("single_ack_once", 32'(req_ack), 0);
    check("single_idle_busy", 32'(busy), 0);
    check("single_idle_grant", 32'(grant), 0);

    // Round-robin
    do_reset();
    set_seq(0, 3, 8'h41, 8'h41, 8'h41, 3'b111);
    set_seq(1, 2, 8'h42, 8'h42, 8'h42, 3'b111);
    set_seq(2, 2, 8'h43, 8'h43, 8'h43, 3'b111);
    run_traffic(4);
    check("rr_count", acc.size(), 4);
    if (acc.size() == 4) begin
      check("rr_b0", 32'(acc[0]), 32'h41);
      check("rr_b1", 32'(acc[1]), 32'h42);
      check("rr_b2", 32'(acc[2]), 32'h43);
      check("rr_b3", 32'(acc[3]), 32'h41);
    end
    check("rr_ack0", ack_cnt[0], 2);
    check("rr_ack1", ack_cnt[1], 1);
    check("rr_ack2", ack_cnt[2], 1);

    // Backpressure, data change after grant ignored
    do_reset();
    req_valid = 3'b010;
    req_data  = 24'h007700;
    tx_ready  = 1'b1;
    wait_valid("bp_wait");
    tx_ready  = 1'b0;
    req_data  = 24'h009900;
    req_valid = 3'b000;
    stable    = 1;
    repeat (50) begin
      @(negedge clk);
      if (!tx_valid || tx_data != 8'h77 || req_ack != 3'b000) stable = 0;
    end
    check("bp_stable", 32'(stable), 1);
    check("bp_grant", 32'(grant), 32'b010);
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp_ack", 32'(req_ack), 32'b010);
    tx_ready = 1'b0;
    @(negedge clk);
    check("bp_ack_once", 32'(req_ack), 0);

    // Packet lock behaviour
    do_reset();
    set_seq(0, 3, 8'h1B, 8'h5B, 8'h48, 3'b100);
    set_seq(1, 3, 8'h20, 8'h20, 8'h20, 3'b111);
    set_seq(2, 0, 8'h00, 8'h00, 8'h00, 3'b111);
    run_traffic(4);
`ifdef UART_ARB_PKTLOCK_EN
    exp31[0] = 8'h1B; exp31[1] = 8'h5B; exp31[2] = 8'h48; exp31[3] = 8'h20;
`else
    exp31[0] = 8'h1B; exp31[1] = 8'h20; exp31[2] = 8'h5B; exp31[3] = 8'h20;
`endif
    check("pkt_count", acc.size(), 4);
    if (acc.size() == 4)
      for (int k = 0; k < 4; k++)
        check($sformatf("pkt_b%0d", k), 32'(acc[k]), 32'(exp31[k]));

    // Reset mid-SEND
    do_reset();
    set_seq(0, 1, 8'h55, 8'h00, 8'h00, 3'b111);
    set_seq(1, 0, 8'h00, 8'h00, 8'h00, 3'b111);
    run_traffic(1);
    req_valid = 3'b010;
    req_data  = 24'h006600;
    tx_ready  = 1'b1;
    wait_valid("rs_wait");
    tx_ready = 1'b0;
    check("rs_pre_grant", 32'(grant), 32'b010);
    rst_n = 1'b0;
    #1;
    check("rs_tx_valid", 32'(tx_valid), 0);
    check("rs_grant", 32'(grant), 0);
    check("rs_busy", 32'(busy), 0);
    @(negedge clk);
    check("rs_no_ack", 32'(req_ack), 0);
    req_valid = 3'b011;
    req_data  = 24'h00A1A0;
    tx_ready  = 1'b1;
    rst_n     = 1'b1;
    wait_valid("rs_post_wait");
    check("rs_first_grant", 32'(grant), 32'b001);
    check("rs_first_data", 32'(tx_data), 32'hA0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
